// File: rtl/cond_exec_ctrl.sv
// cond_exec_ctrl: EXE-stage condition-execution controller.
//
// Holds the architectural status register {Z,C,N,V} and checks each
// instruction's 4-bit condition field against it. It gates the write-back and
// memory enables, updates the flags from the ALU, raises branch-taken/flush and
// then runs a squash window. The window kills wrong-path instructions that
// reach EXE after a taken branch.
//
// Optional feature: define COND_STATS_EN to build the saturating
// executed/squashed instruction counters. Without it, both count outputs are
// tied to zero and no counter flops are built.
//
// Parameters:
//   SQUASH_CYCLES  number of non-stalled cycles killed after a taken branch (0..7)
//   CNT_W          width of the statistics counters
//
// Ports:
//   i_Clk, i_Reset_n          clock, asynchronous active-low reset
//   i_Stall                   EXE held: no state update, no branch pulse
//   i_Valid                   EXE holds a real instruction (0 = bubble)
//   i_Condition               condition field (EQ..AL, 1111 = never)
//   i_S, i_Alu_Flags          flag-update request and ALU flags {Z,C,N,V}
//   i_Wb_En, i_Mem_R_En,
//   i_Mem_W_En, i_Branch      decoded enables / branch marker
//   o_Status                  registered status {Z,C,N,V}
//   o_Exec                    instruction executes this cycle
//   o_Wb_En, o_Mem_R_En,
//   o_Mem_W_En                enables gated by o_Exec
//   o_Branch_Taken, o_Flush   taken-branch pulse and pipeline flush
//   o_Exec_Count,
//   o_Squash_Count            statistics counters (zero unless COND_STATS_EN)
//   o_Dbg_Squash, o_Dbg_Cnt   debug view of FSM state and squash counter
//
// Handshake: there is no valid/ready pair. An instruction is consumed on
// every rising edge where i_Stall=0. While i_Stall=1, the outputs keep
// describing the held instruction but nothing commits.

module cond_exec_ctrl #(
  parameter int SQUASH_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             i_Clk,
  input  logic             i_Reset_n,
  input  logic             i_Stall,
  input  logic             i_Valid,
  input  logic [3:0]       i_Condition,
  input  logic             i_S,
  input  logic [3:0]       i_Alu_Flags,
  input  logic             i_Wb_En,
  input  logic             i_Mem_R_En,
  input  logic             i_Mem_W_En,
  input  logic             i_Branch,
  output logic [3:0]       o_Status,
  output logic             o_Exec,
  output logic             o_Wb_En,
  output logic             o_Mem_R_En,
  output logic             o_Mem_W_En,
  output logic             o_Branch_Taken,
  output logic             o_Flush,
  output logic [CNT_W-1:0] o_Exec_Count,
  output logic [CNT_W-1:0] o_Squash_Count,
  output logic             o_Dbg_Squash,
  output logic [2:0]       o_Dbg_Cnt
);

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

  // Counter starts at SQUASH_CYCLES-1, so the window lasts SQUASH_CYCLES
  // non-stalled cycles, including the cycle on which cnt reaches zero.
  localparam logic [2:0] LOAD_VAL = (SQUASH_CYCLES > 0) ? 3'(SQUASH_CYCLES - 1) : 3'd0;
  localparam bit         ARM_EN   = (SQUASH_CYCLES > 0);

  state_t     state;
  logic [2:0] cnt;
  logic [3:0] status;
  logic       pass;
  logic       kill;
  logic       z, c, n, v;

  assign z = status[3];
  assign c = status[2];
  assign n = status[1];
  assign v = status[0];

  always_comb begin
    pass = 1'b0;
    case (i_Condition)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = ~z & (n == v);
      4'b1101: pass = z | (n != v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

  assign kill           = (state == SQUASH);
  assign o_Exec         = i_Valid & pass & ~kill;
  assign o_Wb_En        = i_Wb_En & o_Exec;
  assign o_Mem_R_En     = i_Mem_R_En & o_Exec;
  assign o_Mem_W_En     = i_Mem_W_En & o_Exec;
  // A stalled branch does not pulse. It pulses on its first unstalled cycle.
  assign o_Branch_Taken = o_Exec & i_Branch & ~i_Stall;
  assign o_Flush        = o_Branch_Taken | kill;
  assign o_Status       = status;
  assign o_Dbg_Squash   = kill;
  assign o_Dbg_Cnt      = cnt;

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state  <= RUN;
      cnt    <= 3'd0;
      status <= 4'd0;
    end else if (!i_Stall) begin
      // o_Exec is already low for failed or killed instructions.
      if (o_Exec & i_S) status <= i_Alu_Flags;
      case (state)
        RUN: begin
          if (o_Branch_Taken && ARM_EN) begin
            state <= SQUASH;
            cnt   <= LOAD_VAL;
          end
        end
        SQUASH: begin
          // Bubbles consume window cycles too. A branch in the window is
          // killed, so it cannot re-arm the window.
          if (cnt == 3'd0) state <= RUN;
          else             cnt   <= cnt - 3'd1;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] squash_cnt;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      exec_cnt   <= '0;
      squash_cnt <= '0;
    end else if (!i_Stall) begin
      // Both counters saturate at all-ones.
      if (o_Exec && (exec_cnt != '1))
        exec_cnt <= exec_cnt + CNT_ONE;
      if (i_Valid && (kill || !pass) && (squash_cnt != '1))
        squash_cnt <= squash_cnt + CNT_ONE;
    end
  end

  assign o_Exec_Count   = exec_cnt;
  assign o_Squash_Count = squash_cnt;
`else
  assign o_Exec_Count   = '0;
  assign o_Squash_Count = '0;
`endif

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Testbench for cond_exec_ctrl. It builds four instances that share one
// stimulus stream. Their SQUASH_CYCLES values are 1, 0, 2 and 3, and the
// SQUASH_CYCLES=2 instance uses CNT_W=4. Each instance is checked against its
// own behavioural model on every cycle. Literal expectations in the directed
// sequence pin down the model itself.

module tb_cond_exec_ctrl;

  localparam int N_INST = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus
  logic       stall = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] cond  = 4'd0;
  logic       s_bit = 1'b0;
  logic [3:0] flags = 4'd0;
  logic       wb = 1'b0, mr = 1'b0, mw = 1'b0, br = 1'b0;

  // per-instance observed outputs
  logic [3:0]  st_a [N_INST];
  logic        ex_a [N_INST];
  logic        wb_a [N_INST];
  logic        mr_a [N_INST];
  logic        mw_a [N_INST];
  logic        bt_a [N_INST];
  logic        fl_a [N_INST];
  logic        dq_a [N_INST];
  logic [15:0] ec_a [N_INST];
  logic [15:0] sc_a [N_INST];

  function automatic int sc_of(input int k);
    case (k)
      0: return 1;
      1: return 0;
      2: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int cw_of(input int k);
    return (k == 2) ? 4 : 16;
  endfunction

  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    localparam int SC = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 2 : 3;
    localparam int CW = (g == 2) ? 4 : 16;
    logic [3:0]    st;
    logic          ex, wbo, mro, mwo, bto, flo, dq;
    logic [2:0]    dc;
    logic [CW-1:0] ec, sq;

    cond_exec_ctrl #(.SQUASH_CYCLES(SC), .CNT_W(CW)) u_dut (
      .i_Clk          (clk),
      .i_Reset_n      (rst_n),
      .i_Stall        (stall),
      .i_Valid        (valid),
      .i_Condition    (cond),
      .i_S            (s_bit),
      .i_Alu_Flags    (flags),
      .i_Wb_En        (wb),
      .i_Mem_R_En     (mr),
      .i_Mem_W_En     (mw),
      .i_Branch       (br),
      .o_Status       (st),
      .o_Exec         (ex),
      .o_Wb_En        (wbo),
      .o_Mem_R_En     (mro),
      .o_Mem_W_En     (mwo),
      .o_Branch_Taken (bto),
      .o_Flush        (flo),
      .o_Exec_Count   (ec),
      .o_Squash_Count (sq),
      .o_Dbg_Squash   (dq),
      .o_Dbg_Cnt      (dc)
    );

    assign st_a[g] = st;
    assign ex_a[g] = ex;
    assign wb_a[g] = wbo;
    assign mr_a[g] = mro;
    assign mw_a[g] = mwo;
    assign bt_a[g] = bto;
    assign fl_a[g] = flo;
    assign dq_a[g] = dq;
    assign ec_a[g] = 16'(ec);
    assign sc_a[g] = 16'(sq);
  end

  // scoreboard counters
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // behavioural model: flags, remaining window cycles, statistics
`ifdef COND_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic [3:0] m_st  [N_INST];
  int         m_win [N_INST];
  int         m_ec  [N_INST];
  int         m_sq  [N_INST];

  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
    logic zf, cf, nf, vf;
    zf = f[3]; cf = f[2]; nf = f[1]; vf = f[0];
    case (cc)
      4'd0:  return zf;
      4'd1:  return !zf;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return nf;
      4'd5:  return !nf;
      4'd6:  return vf;
      4'd7:  return !vf;
      4'd8:  return cf && !zf;
      4'd9:  return !cf || zf;
      4'd10: return nf == vf;
      4'd11: return nf != vf;
      4'd12: return !zf && (nf == vf);
      4'd13: return zf || (nf != vf);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N_INST; k++) begin
      m_st[k] = 4'd0; m_win[k] = 0; m_ec[k] = 0; m_sq[k] = 0;
    end
  endtask

  initial model_reset();

  // compare process: checks settled outputs, then advances the model at the edge
  always begin
    logic e_ex, e_bt, p;
    int   sat;
    @(negedge clk);
    #3;
    if (!rst_n) model_reset();
    for (int k = 0; k < N_INST; k++) begin
      p    = cond_ok(cond, m_st[k]);
      e_ex = valid && p && (m_win[k] == 0);
      e_bt = e_ex && br && !stall;
      chk("status", k, 16'(st_a[k]), 16'(m_st[k]));
      chk("exec",   k, 16'(ex_a[k]), 16'(e_ex));
      chk("wb_en",  k, 16'(wb_a[k]), 16'(wb && e_ex));
      chk("mem_r",  k, 16'(mr_a[k]), 16'(mr && e_ex));
      chk("mem_w",  k, 16'(mw_a[k]), 16'(mw && e_ex));
      chk("br_tkn", k, 16'(bt_a[k]), 16'(e_bt));
      chk("flush",  k, 16'(fl_a[k]), 16'(e_bt || (m_win[k] > 0)));
      chk("dbg_sq", k, 16'(dq_a[k]), 16'(m_win[k] > 0));
      chk("ex_cnt", k, ec_a[k], STATS ? 16'(m_ec[k]) : 16'd0);
      chk("sq_cnt", k, sc_a[k], STATS ? 16'(m_sq[k]) : 16'd0);
    end
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (!stall) begin
      for (int k = 0; k < N_INST; k++) begin
        p    = cond_ok(cond, m_st[k]);
        e_ex = valid && p && (m_win[k] == 0);
        sat  = (1 << cw_of(k)) - 1;
        if (valid && (m_win[k] > 0 || !p) && m_sq[k] < sat) m_sq[k]++;
        if (e_ex && m_ec[k] < sat) m_ec[k]++;
        if (e_ex && s_bit) m_st[k] = flags;
        if (m_win[k] > 0) m_win[k]--;
        else if (e_ex && br) m_win[k] = sc_of(k);
      end
    end
  end

  // driver: apply one instruction at negedge+1; literal checks follow at +2
  task automatic drv(input logic v, input logic [3:0] c, input logic s, input logic [3:0] f,
                     input logic w, input logic r, input logic m, input logic b, input logic stl);
    @(negedge clk);
    #1;
    valid = v; cond = c; s_bit = s; flags = f;
    wb = w; mr = r; mw = m; br = b; stall = stl;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  localparam logic [3:0] AL = 4'b1110;
  localparam logic [3:0] NV = 4'b1111;

  initial begin
    logic [3:0] pats [4];
    pats[0] = 4'b0100; pats[1] = 4'b1001; pats[2] = 4'b0011; pats[3] = 4'b0010;

    // reset
    idle(); idle();
    for (int k = 0; k < N_INST; k++) begin
      chk("rst_status", k, 16'(st_a[k]), 16'd0);
      chk("rst_flush",  k, 16'(fl_a[k]), 16'd0);
      chk("rst_excnt",  k, ec_a[k], 16'd0);
    end
    @(negedge clk); #1 rst_n = 1'b1;
    idle();

    // ADDS sets Z, then BEQ is taken
    drv(1'b1, AL, 1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("adds_exec", 0, 16'(ex_a[0]), 16'd1);
    chk("adds_wb",   0, 16'(wb_a[0]), 16'd1);
    drv(1'b1, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("beq_status", 0, 16'(st_a[0]), 16'h8);
    chk("beq_taken",  0, 16'(bt_a[0]), 16'd1);
    chk("beq_flush",  0, 16'(fl_a[0]), 16'd1);

    // three AL flag-setting instructions after the branch
    drv(1'b1, AL, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("w2_a_exec", 2, 16'(ex_a[2]), 16'd0);
    chk("w2_a_fl",   2, 16'(fl_a[2]), 16'd1);
    chk("w0_a_exec", 1, 16'(ex_a[1]), 16'd1);
    chk("w0_a_fl",   1, 16'(fl_a[1]), 16'd0);
    chk("w1_a_exec", 0, 16'(ex_a[0]), 16'd0);
    drv(1'b1, AL, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("w2_b_exec", 2, 16'(ex_a[2]), 16'd0);
    chk("w2_b_st",   2, 16'(st_a[2]), 16'h8);
    chk("w1_b_exec", 0, 16'(ex_a[0]), 16'd1);
    chk("w0_b_st",   1, 16'(st_a[1]), 16'h1);
    drv(1'b1, AL, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("w2_c_exec", 2, 16'(ex_a[2]), 16'd1);
    chk("w2_c_fl",   2, 16'(fl_a[2]), 16'd0);
    chk("w3_c_exec", 3, 16'(ex_a[3]), 16'd0);
    chk("w3_c_fl",   3, 16'(fl_a[3]), 16'd1);
    idle();
    chk("w2_d_st", 2, 16'(st_a[2]), 16'h1);
    chk("w3_d_st", 3, 16'(st_a[3]), 16'h8);
    chk("w3_d_fl", 3, 16'(fl_a[3]), 16'd0);

    // LS fails with C=1,Z=0: enables gated, flags untouched
    drv(1'b1, AL, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 4'b1001, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ls_exec", 0, 16'(ex_a[0]), 16'd0);
    chk("ls_wb",   0, 16'(wb_a[0]), 16'd0);
    chk("ls_mw",   0, 16'(mw_a[0]), 16'd0);
    idle();
    chk("ls_status", 0, 16'(st_a[0]), 16'h4);

    // condition sweep over several flag patterns
    for (int p = 0; p < 4; p++) begin
      drv(1'b1, AL, 1'b1, pats[p], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 16; c++) begin
        drv(1'b1, 4'(c), 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        if (pats[p] == 4'b0011 && c == 10) chk("ge_nv", 0, 16'(ex_a[0]), 16'd1);
        if (pats[p] == 4'b0011 && c == 11) chk("lt_nv", 0, 16'(ex_a[0]), 16'd0);
        if (pats[p] == 4'b1001 && c == 12) chk("gt_z",  0, 16'(ex_a[0]), 16'd0);
        if (pats[p] == 4'b1001 && c == 13) chk("le_z",  0, 16'(mr_a[0]), 16'd1);
        if (pats[p] == 4'b0100 && c == 8)  chk("hi_c",  0, 16'(ex_a[0]), 16'd1);
      end
    end

    // taken branch held by a stall, then window with stall, bubble and inner branch
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, AL, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("stl_bt",   3, 16'(bt_a[3]), 16'd0);
      chk("stl_fl",   3, 16'(fl_a[3]), 16'd0);
      chk("stl_exec", 3, 16'(ex_a[3]), 16'd1);
    end
    drv(1'b1, AL, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rel_bt", 3, 16'(bt_a[3]), 16'd1);
    drv(1'b1, AL, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("inner_bt", 3, 16'(bt_a[3]), 16'd0);
    chk("inner_fl", 3, 16'(fl_a[3]), 16'd1);
    drv(1'b1, AL, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("wstl_fl", 3, 16'(fl_a[3]), 16'd1);
    idle();
    drv(1'b1, AL, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("w3_last_exec", 3, 16'(ex_a[3]), 16'd0);
    drv(1'b1, AL, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("w3_after_exec", 3, 16'(ex_a[3]), 16'd1);
    chk("w3_after_fl",   3, 16'(fl_a[3]), 16'd0);

    // async reset one cycle into a SQUASH_CYCLES=3 window
    drv(1'b1, AL, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b1, AL, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drv(1'b1, AL, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_fl", 3, 16'(fl_a[3]), 16'd1);
    @(negedge clk); #1 rst_n = 1'b0; #1;
    chk("arst_status", 3, 16'(st_a[3]), 16'd0);
    chk("arst_flush",  3, 16'(fl_a[3]), 16'd0);
    chk("arst_dbg",    3, 16'(dq_a[3]), 16'd0);
    chk("arst_cnt",    3, ec_a[3], 16'd0);
    idle();
    @(negedge clk); #1 rst_n = 1'b1;

    // saturation: 20 executed, 3 never-condition
    for (int i = 0; i < 20; i++) drv(1'b1, AL, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)  drv(1'b1, NV, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("sat_cw4",  2, ec_a[2], STATS ? 16'd15 : 16'd0);
    chk("cnt_cw16", 0, ec_a[0], STATS ? 16'd20 : 16'd0);
    chk("sq_nv",    0, sc_a[0], STATS ? 16'd3  : 16'd0);
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cond_exec_ctrl.md
Name: cond_exec_ctrl

Overview:
- EXE-stage condition-execution controller for the pipelined ARM core.
- Owns the architectural status register in {Z,C,N,V} order and evaluates each instruction's 4-bit condition field against it.
- Gates the write-back and memory enables, and sets flags from the ALU.
- Issues branch-taken/flush, then runs a squash window that kills wrong-path instructions reaching EXE.

Parameters:
SQUASH_CYCLES, 1, cycles after a taken branch during which valid EXE instructions are killed (legal 0..7)
CNT_W, 16, width of the optional statistics counters

Ports:
i_Clk  input  1  clock; all state updates on rising edge
i_Reset_n  input  1  asynchronous active-low reset
i_Stall  input  1  EXE stage held this cycle; no state update
i_Valid  input  1  EXE holds a real instruction (0 = bubble)
i_Condition  input  4  instruction condition field
i_S  input  1  instruction requests flag update
i_Alu_Flags  input  4  ALU result flags {Z,C,N,V}
i_Wb_En  input  1  decoded write-back enable
i_Mem_R_En  input  1  decoded memory read enable
i_Mem_W_En  input  1  decoded memory write enable
i_Branch  input  1  instruction is a branch
o_Status  output  4  registered status {Z,C,N,V}
o_Exec  output  1  instruction executes this cycle
o_Wb_En  output  1  gated write-back enable
o_Mem_R_En  output  1  gated memory read enable
o_Mem_W_En  output  1  gated memory write enable
o_Branch_Taken  output  1  taken-branch pulse to fetch
o_Flush  output  1  flush IF/ID and ID/EXE
o_Exec_Count  output  CNT_W  executed-instruction count (optional feature)
o_Squash_Count  output  CNT_W  squashed-instruction count (optional feature)

Behaviour:
- Reset (async, i_Reset_n=0): o_Status=0; FSM=RUN; squash counter=0; stats counters=0. Reset during a squash window aborts the window at once.
- Condition pass, evaluated combinationally on o_Status:
  - EQ 0000: Z. NE 0001: !Z.
  - CS 0010: C. CC 0011: !C.
  - MI 0100: N. PL 0101: !N.
  - VS 0110: V. VC 0111: !V.
  - HI 1000: C&!Z. LS 1001: !C|Z.
  - GE 1010: N==V. LT 1011: N!=V.
  - GT 1100: !Z&(N==V). LE 1101: Z|(N!=V).
  - AL 1110: 1. 1111: 0 (never).
- kill = (FSM==SQUASH).
- o_Exec = i_Valid & pass & !kill, combinational, zero latency.
- o_Wb_En, o_Mem_R_En, o_Mem_W_En are the corresponding inputs ANDed with o_Exec. They still drive during a stall; the EXE register holds the instruction.
- o_Branch_Taken = o_Exec & i_Branch & !i_Stall, combinational.
- o_Flush = o_Branch_Taken | kill.
- Status update at the clock edge: if o_Exec & i_S & !i_Stall, then o_Status <= i_Alu_Flags. A failed or killed instruction never changes flags. The next instruction sees the new flags one cycle later; no forwarding is needed.
- FSM states:
  - RUN: on o_Branch_Taken with SQUASH_CYCLES>0, go to SQUASH and load cnt=SQUASH_CYCLES-1. With SQUASH_CYCLES=0, stay in RUN.
  - SQUASH: each non-stalled cycle, if cnt==0 go to RUN, else cnt--. A branch inside the window is killed and does not re-arm it.
- i_Stall=1 freezes the FSM, the squash counter, the status register and the stats counters.
- A bubble (i_Valid=0) in the window still consumes a window cycle.
- Simultaneous stall and taken branch: no pulse and no FSM change until the stall releases.

Optional Feature:
- Macro COND_STATS_EN.
- Defined:
  - o_Exec_Count increments on each non-stalled cycle with o_Exec=1.
  - o_Squash_Count increments on each non-stalled cycle with i_Valid & (kill | !pass).
  - Both counters saturate at all-ones and never wrap.
- Undefined: both outputs are tied to 0, no counter flops are built, and the ports remain present.

Test Plan:
- Reset with i_Reset_n=0 mid-window (SQUASH_CYCLES=3, 1 cycle in) -> o_Status=0000, o_Flush=0, FSM=RUN immediately; counters=0.
- ADDS with i_Condition=1110, i_S=1, i_Alu_Flags=1000 -> next cycle o_Status=1000. Then BEQ with i_Condition=0000, i_Branch=1 -> o_Branch_Taken=1, o_Flush=1.
- o_Status=0100 (C=1,Z=0), i_Condition=1001 (LS), i_Wb_En=1, i_Mem_W_En=1 -> o_Exec=0, o_Wb_En=0, o_Mem_W_En=0, o_Status unchanged despite i_S=1.
- SQUASH_CYCLES=2, taken branch followed by 2 valid AL instructions with i_S=1 -> both killed (o_Exec=0, o_Flush=1), flags unchanged; the 3rd instruction executes.
- Taken branch with i_Stall=1 for 3 cycles -> o_Branch_Taken=0 throughout. Pulse of 1 cycle on the first unstalled cycle; window starts after it.
- COND_STATS_EN with CNT_W=4: 20 executing instructions -> o_Exec_Count=15 and holds. Without the macro, both count outputs =0.
